// File: rtl/sram_ctrl.sv
// Bridges a 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM as two
// halfword beats (LO then HI), with optional settle cycles and a one-cycle DONE handshake.
module sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_t      state;
  req_t        req_q;
  logic [3:0]  wait_cnt;
  logic [16:0] word_in;
  logic [16:0] word_q;

  // Window-relative word index; the subtraction wraps so addresses below the base alias high.
  assign word_in = 17'((address - BASE_ADDR) >> 2);
  assign word_q  = 17'((req_q.addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '0;
      wait_cnt    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            state       <= LO;
            req_q.wr    <= wr_en;
            req_q.addr  <= address;
            req_q.data  <= write_data;
            sram_addr   <= {word_in, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LO: begin
          state     <= HI;
          sram_addr <= {word_q, 1'b1};
          if (req_q.wr) sram_dq_out     <= req_q.data[31:16];
          else          read_data[15:0] <= sram_dq_in;
        end
        HI: begin
          if (!req_q.wr) read_data[31:16] <= sram_dq_in;
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
          wait_cnt   <= '0;
          state      <= (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= DONE;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Idle acknowledges only when nothing is asked, so the pipeline stalls on the request cycle.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~(rd_en | wr_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Checks two controllers (WAIT_CYCLES 2 and 0) against a cycle-indexed access model
// plus an SRAM array, with literal expectations on the directed vectors.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_v[2], wr_v[2], ready_v[2], soe_v[2], swe_v[2];
  logic [31:0] addr_v[2], wdata_v[2], rdata_v[2];
  logic [17:0] saddr_v[2];
  logic [15:0] sdo_v[2], sdi_v[2];

  int n_tests = 0;
  int n_fail  = 0;

  // model: k = cycles since acceptance (0 = idle)
  int          k[2];
  logic        mw[2];
  logic [16:0] mword[2];
  logic [31:0] md[2], mrd[2];
  logic [17:0] mlast[2];
  logic [15:0] sram [int];
  logic [15:0] refm [int];

  logic        rec_ready[2][16], rec_we[2][16], rec_oe[2][16];
  logic [17:0] rec_addr[2][16];
  logic [15:0] rec_dq[2][16];
  logic [31:0] rec_rd[2][16];
  int          rc;

  sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .rd_en(rd_v[0]), .wr_en(wr_v[0]), .address(addr_v[0]),
    .write_data(wdata_v[0]), .read_data(rdata_v[0]), .ready(ready_v[0]),
    .sram_addr(saddr_v[0]), .sram_dq_out(sdo_v[0]), .sram_dq_oe(soe_v[0]),
    .sram_dq_in(sdi_v[0]), .sram_we_n(swe_v[0]));

  sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_v[1]), .wr_en(wr_v[1]), .address(addr_v[1]),
    .write_data(wdata_v[1]), .read_data(rdata_v[1]), .ready(ready_v[1]),
    .sram_addr(saddr_v[1]), .sram_dq_out(sdo_v[1]), .sram_dq_oe(soe_v[1]),
    .sram_dq_in(sdi_v[1]), .sram_we_n(swe_v[1]));

  always #5 clk = ~clk;

  function automatic int lat(int i);
    return (i == 0) ? 5 : 3;
  endfunction

  function automatic logic [15:0] pat(logic [17:0] a);
    return a[15:0] ^ 16'hC3C3;
  endfunction

  function automatic int key(int i, logic [17:0] a);
    return i * 262144 + int'(a);
  endfunction

  function automatic logic [16:0] word_of(logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  function automatic logic [15:0] ref_rd(int i, logic [17:0] a);
    return refm.exists(key(i, a)) ? refm[key(i, a)] : pat(a);
  endfunction

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; mw[i] = 1'b0; mword[i] = '0; md[i] = '0; mrd[i] = '0; mlast[i] = '0;
    end
  endtask

  task automatic model_adv();
    for (int i = 0; i < 2; i++) begin
      if (k[i] == 0) begin
        if (rd_v[i] | wr_v[i]) begin
          k[i] = 1; mw[i] = wr_v[i]; mword[i] = word_of(addr_v[i]); md[i] = wdata_v[i];
          if (wr_v[i]) begin
            refm[key(i, {word_of(addr_v[i]), 1'b0})] = wdata_v[i][15:0];
            refm[key(i, {word_of(addr_v[i]), 1'b1})] = wdata_v[i][31:16];
          end
        end
      end else begin
        if (k[i] == 1 && !mw[i]) mrd[i][15:0] = ref_rd(i, {mword[i], 1'b0});
        if (k[i] == 2) begin
          if (!mw[i]) mrd[i][31:16] = ref_rd(i, {mword[i], 1'b1});
          mlast[i] = {mword[i], 1'b1};
        end
        k[i] = (k[i] == lat(i)) ? 0 : k[i] + 1;
      end
    end
  endtask

  // SRAM device: strobed writes land, read data is presented for the next edge.
  task automatic sram_io();
    for (int i = 0; i < 2; i++) begin
      if (!swe_v[i]) sram[key(i, saddr_v[i])] = sdo_v[i];
      sdi_v[i] = sram.exists(key(i, saddr_v[i])) ? sram[key(i, saddr_v[i])] : pat(saddr_v[i]);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic strobe, exp_rdy;
      logic [17:0] exp_addr;
      strobe   = mw[i] && (k[i] == 1 || k[i] == 2);
      exp_rdy  = (k[i] == 0) ? !(rd_v[i] | wr_v[i]) : (k[i] == lat(i));
      exp_addr = (k[i] == 0) ? mlast[i] : {mword[i], (k[i] >= 2)};
      chk("ready", i, 32'(ready_v[i]), 32'(exp_rdy));
      chk("we_n", i, 32'(swe_v[i]), 32'(!strobe));
      chk("dq_oe", i, 32'(soe_v[i]), 32'(strobe));
      chk("sram_addr", i, 32'(saddr_v[i]), 32'(exp_addr));
      chk("read_data", i, rdata_v[i], mrd[i]);
      if (strobe) chk("dq_out", i, 32'(sdo_v[i]), (k[i] == 1) ? 32'(md[i][15:0]) : 32'(md[i][31:16]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    sram_io();
    compare();
    for (int i = 0; i < 2; i++) begin
      rec_ready[i][rc] = ready_v[i]; rec_we[i][rc] = swe_v[i]; rec_oe[i][rc] = soe_v[i];
      rec_addr[i][rc] = saddr_v[i]; rec_dq[i][rc] = sdo_v[i]; rec_rd[i][rc] = rdata_v[i];
    end
    if (rc < 15) rc++;
    if (!rst) model_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(int i, logic rd, logic wr, logic [31:0] a, logic [31:0] d, int hold, int n);
    rd_v[i] = rd; wr_v[i] = wr; addr_v[i] = a; wdata_v[i] = d;
    rc = 0;
    for (int c = 0; c < n; c++) begin
      step();
      if (c + 1 == hold) begin rd_v[i] = 1'b0; wr_v[i] = 1'b0; end
    end
  endtask

  initial begin
    int lows;
    for (int i = 0; i < 2; i++) begin
      rd_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0; sdi_v[i] = '0;
    end
    rc = 0;
    rst = 1'b1;
    model_reset();
    step(); step();
    chk("rst_we_n", 0, 32'(swe_v[0]), 32'd1);
    chk("rst_ready", 0, 32'(ready_v[0]), 32'd1);
    chk("rst_read_data", 0, rdata_v[0], 32'd0);
    rst = 1'b0;
    step();

    // write 0xDEADBEEF at the window base
    run_access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1, 8);
    chk("wr_lo_addr", 0, 32'(rec_addr[0][1]), 32'd0);
    chk("wr_lo_dq", 0, 32'(rec_dq[0][1]), 32'h0000BEEF);
    chk("wr_lo_we_n", 0, 32'(rec_we[0][1]), 32'd0);
    chk("wr_hi_addr", 0, 32'(rec_addr[0][2]), 32'd1);
    chk("wr_hi_dq", 0, 32'(rec_dq[0][2]), 32'h0000DEAD);
    chk("wr_hi_we_n", 0, 32'(rec_we[0][2]), 32'd0);
    lows = 0;
    for (int c = 0; c < 5; c++) if (rec_ready[0][c] == 1'b0) lows++;
    chk("wr_ready_low_cycles", 0, 32'(lows), 32'd5);
    chk("wr_ready_done", 0, 32'(rec_ready[0][5]), 32'd1);

    // read it back
    run_access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1, 7);
    chk("rd_data", 0, rec_rd[0][5], 32'hDEADBEEF);
    chk("rd_ready_done", 0, 32'(rec_ready[0][5]), 32'd1);
    for (int c = 0; c < 7; c++) chk("rd_dq_oe", 0, 32'(rec_oe[0][c]), 32'd0);

    // addressing and wrap
    run_access(0, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 1, 7);
    chk("a1036_lo", 0, 32'(rec_addr[0][1]), 32'd6);
    chk("a1036_hi", 0, 32'(rec_addr[0][2]), 32'd7);
    run_access(0, 1'b0, 1'b1, 32'd1039, 32'h01234567, 1, 7);
    chk("a1039_lo", 0, 32'(rec_addr[0][1]), 32'd6);
    chk("a1039_hi", 0, 32'(rec_addr[0][2]), 32'd7);
    run_access(0, 1'b1, 1'b0, 32'd1036, 32'h0, 1, 7);
    chk("a1036_rd", 0, rec_rd[0][5], 32'h01234567);
    run_access(0, 1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 1, 7);
    chk("wrap_lo", 0, 32'(rec_addr[0][1]), 32'h3FFFE);
    chk("wrap_hi", 0, 32'(rec_addr[0][2]), 32'h3FFFF);

    // both enables: write wins, read_data untouched
    run_access(0, 1'b1, 1'b1, 32'd1028, 32'h11112222, 1, 7);
    chk("prio_we_n", 0, 32'(rec_we[0][1]), 32'd0);
    chk("prio_dq", 0, 32'(rec_dq[0][1]), 32'h00002222);
    chk("prio_rd_hold", 0, rec_rd[0][5], 32'h01234567);
    // rd_en dropped after LO: read still completes
    run_access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 2, 7);
    chk("drop_rd", 0, rec_rd[0][5], 32'h11112222);

    // reset during HI of a write, request held across it
    rd_v[0] = 1'b0; wr_v[0] = 1'b1; addr_v[0] = 32'd1032; wdata_v[0] = 32'h55667788;
    step(); step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("abort_we_n", 0, 32'(swe_v[0]), 32'd1);
    chk("abort_dq_oe", 0, 32'(soe_v[0]), 32'd0);
    chk("abort_read_data", 0, rdata_v[0], 32'd0);
    chk("abort_ready", 0, 32'(ready_v[0]), 32'd0);
    step(); step();
    rst = 1'b0;
    run_access(0, 1'b0, 1'b1, 32'd1032, 32'h55667788, 1, 7);
    chk("restart_lo_addr", 0, 32'(rec_addr[0][1]), 32'd4);
    chk("restart_lo_we_n", 0, 32'(rec_we[0][1]), 32'd0);
    chk("restart_lo_dq", 0, 32'(rec_dq[0][1]), 32'h00007788);
    chk("restart_hi_dq", 0, 32'(rec_dq[0][2]), 32'h00005566);
    chk("restart_done", 0, 32'(rec_ready[0][5]), 32'd1);

    // WAIT_CYCLES=0: back-to-back reads, unwritten SRAM returns the fill pattern
    rd_v[1] = 1'b1; addr_v[1] = 32'd1024;
    rc = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 3) addr_v[1] = 32'd1028;
      if (c == 6) rd_v[1] = 1'b0;
    end
    for (int c = 0; c < 8; c++)
      chk("b2b_ready", c, 32'(rec_ready[1][c]), (c == 3 || c == 7) ? 32'd1 : 32'd0);
    chk("b2b_rd0", 1, rec_rd[1][3], 32'hC3C2C3C3);
    chk("b2b_rd1", 1, rec_rd[1][7], 32'hC3C0C3C1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'd1024, start of the data-memory window in the ALU address space.
REQ-002 Parameter WAIT_CYCLES, default 2, extra SRAM settle cycles per access (range 0..15).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rd_en  in  1  MEM-stage load request.
REQ-006 wr_en  in  1  MEM-stage store request.
REQ-007 address  in  32  ALU-computed byte address.
REQ-008 write_data  in  32  store data.
REQ-009 read_data  out  32  registered load result.
REQ-010 ready  out  1  access complete; pipeline freezes while 0.
REQ-011 sram_addr  out  18  SRAM halfword address.
REQ-012 sram_dq_out  out  16  SRAM write data.
REQ-013 sram_dq_oe  out  1  SRAM data-bus drive enable.
REQ-014 sram_dq_in  in  16  SRAM read data.
REQ-015 sram_we_n  out  1  SRAM write strobe, active-low.

Function
REQ-016 States: IDLE, LO, HI, WAIT, DONE; the FSM SHALL be one-hot or encoded, with no other reachable state.
REQ-017 IDLE: any of rd_en|wr_en -> LO; else stay IDLE.
REQ-018 On the IDLE->LO edge, op (write if wr_en, else read), address and write_data SHALL be latched; wr_en wins if both are high.
REQ-019 offset = (address - BASE_ADDR) mod 2^32; word = offset[18:2]; bits [1:0] and [31:19] ignored.
REQ-020 LO: sram_addr = {word,1'b0}; write: sram_dq_out = data[15:0], sram_dq_oe = 1, sram_we_n = 0; read: sram_dq_oe = 0, sram_we_n = 1, read_data[15:0] <= sram_dq_in at the edge leaving LO; -> HI.
REQ-021 HI: sram_addr = {word,1'b1}; data[31:16] handled as in LO; -> WAIT if WAIT_CYCLES > 0, else -> DONE.
REQ-022 WAIT: the counter is loaded with 0 on entry and leaves to DONE after exactly WAIT_CYCLES cycles in WAIT.
REQ-023 In WAIT and DONE: sram_we_n = 1, sram_dq_oe = 0, and sram_addr holds its last value.
REQ-024 DONE: -> IDLE unconditionally, one cycle.
REQ-025 ready (combinational) = 1 in DONE; = ~(rd_en|wr_en) in IDLE; = 0 in LO, HI, WAIT.
REQ-026 Latency: a request presented in IDLE holds ready low for 3+WAIT_CYCLES cycles; ready is high in the following cycle (DONE).
REQ-027 Request inputs changing or dropping after the latch edge SHALL NOT affect the in-flight access; it completes fully.
REQ-028 read_data SHALL change only on read accesses (LO/HI edges) and hold otherwise, including across writes.
REQ-029 A new request in the IDLE cycle directly after DONE SHALL start a new access; there are no idle-gap requirements.
REQ-030 sram_we_n SHALL never be low outside LO/HI of a write; sram_dq_oe SHALL never be high during a read.

Reset
REQ-031 On rst: state = IDLE, wait counter = 0, read_data = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1, latched op/address/data = 0.
REQ-032 rst mid-access (any state) aborts immediately; after release the FSM starts in IDLE, and a held request starts a fresh access.
REQ-033 During rst, ready follows the IDLE rule.

Verification
REQ-034 Write: wr_en=1, address=1024, write_data=0xDEADBEEF, WAIT_CYCLES=2 -> cycle 1: sram_addr=0, dq_out=0xBEEF, we_n=0; cycle 2: sram_addr=1, dq_out=0xDEAD, we_n=0; ready low 5 cycles, then high 1 cycle.
REQ-035 Read back: rd_en=1, address=1024, SRAM model returns 0xBEEF/0xDEAD -> read_data=0xDEADBEEF when ready=1; dq_oe=0 throughout.
REQ-036 Addressing: address=1036 -> sram_addr 6 then 7; address=1039 gives the same addresses; address=1020 wraps to word 0x1FFFF -> sram_addr 0x3FFFE/0x3FFFF.
REQ-037 Priority/hold: rd_en=wr_en=1 -> write performed; rd_en dropped after LO -> read still completes and updates read_data.
REQ-038 rst asserted in HI of a write -> we_n=1, dq_oe=0, read_data=0 immediately; request held after release -> full access restarts at LO.
REQ-039 WAIT_CYCLES=0: back-to-back reads at 1024 and 1028 -> ready pattern 0,0,0,1,0,0,0,1; no idle gap between accesses.
